// File: rtl/npcg_toggle_cmd_queue.sv
// Command FIFO between the upstream command source and the blocking-command manager.
// Registered-only handshake flags; head fields read as zero while the queue is empty.
module npcg_toggle_cmd_queue #(
  parameter int NumberOfWays = 4,
  parameter int QueueDepth   = 4
) (
  input  logic                    iSystemClock,
  input  logic                    iReset_n,
  input  logic                    iFlush,
  input  logic                    iCMDValid,
  output logic                    oCMDReady,
  input  logic [5:0]              iOpcode,
  input  logic [4:0]              iTargetID,
  input  logic [4:0]              iSourceID,
  input  logic [NumberOfWays-1:0] iTargetWay,
  output logic                    oCMDValid,
  input  logic                    iCMDReady,
  output logic [5:0]              oOpcode,
  output logic [4:0]              oTargetID,
  output logic [4:0]              oSourceID,
  output logic [NumberOfWays-1:0] oTargetWay,
  output logic [$clog2(QueueDepth):0] oQueueCount,
  output logic                    oQueueEmpty,
  output logic                    oQueueFull
);

  localparam int PtrW = $clog2(QueueDepth);
  localparam int EntW = 16 + NumberOfWays;
  localparam logic [PtrW:0] FullCount = (PtrW+1)'(QueueDepth);

  logic [EntW-1:0] mem_q [QueueDepth];
  logic [EntW-1:0] head;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            empty, full, push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);
  // Handshakes depend only on registered occupancy; a push while full is refused even if a pop happens.
  assign push  = iCMDValid & ~full & ~iFlush;
  assign pop   = ~empty & iCMDReady & ~iFlush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (iFlush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_d = count_q + (PtrW+1)'(1);
      else if (pop && !push) count_d = count_q - (PtrW+1)'(1);
    end
  end

  always_ff @(posedge iSystemClock or negedge iReset_n) begin
    if (!iReset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is left unreset; stale contents never reach the outputs.
  always_ff @(posedge iSystemClock) begin
    if (push) mem_q[wr_ptr_q] <= {iOpcode, iTargetID, iSourceID, iTargetWay};
  end

  assign head = empty ? '0 : mem_q[rd_ptr_q];

  assign oOpcode     = head[EntW-1 -: 6];
  assign oTargetID   = head[EntW-7 -: 5];
  assign oSourceID   = head[EntW-12 -: 5];
  assign oTargetWay  = head[NumberOfWays-1:0];
  assign oCMDValid   = ~empty;
  assign oCMDReady   = ~full;
  assign oQueueCount = count_q;
  assign oQueueEmpty = empty;
  assign oQueueFull  = full;

endmodule
